// File: rtl/param_arb_mux.sv
// ============================================================================
// Module   : param_arb_mux
// Brief    : N-channel arbitrating mux (fixed-select or round-robin) feeding a
//            single-entry registered output stage with valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module param_arb_mux #(
  parameter int K = 2,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [K-1:0]         sel,
  input  logic [(2**K)-1:0]    inValid,
  input  logic [W*(2**K)-1:0]  inData,
  output logic [(2**K)-1:0]    inReady,
  output logic                 outValid,
  output logic [W-1:0]         outData,
  output logic [K-1:0]         outChan,
  input  logic                 outReady
);

  localparam int N = 2**K;

  logic [K-1:0] r_ptr;
  logic         r_valid;
  logic [W-1:0] r_data;
  logic [K-1:0] r_chan;

  logic         w_ld;
  logic         w_gvalid;
  logic [K-1:0] w_gidx;
  logic [K-1:0] w_cand;
  logic [N-1:0] w_grant;
  logic         w_xfer;
  logic [W-1:0] w_chan [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_chan[gi] = inData[W*gi +: W];
  end

  // rst gates ld so inReady is forced low for as long as reset is held
  assign w_ld = (!r_valid | outReady) & !rst;

  // Round-robin scans offsets downwards so the smallest offset from ptr wins.
  always_comb begin
    w_gvalid = 1'b0;
    w_gidx   = '0;
    w_cand   = '0;
    if (!mode) begin
      if (inValid[sel]) begin
        w_gvalid = 1'b1;
        w_gidx   = sel;
      end
    end else begin
      for (int j = N-1; j >= 0; j--) begin
        w_cand = r_ptr + K'(j);
        if (inValid[w_cand]) begin
          w_gvalid = 1'b1;
          w_gidx   = w_cand;
        end
      end
    end
  end

  assign w_grant = w_gvalid ? (N'(1) << w_gidx) : '0;
  assign inReady = w_ld ? w_grant : '0;
  assign w_xfer  = w_gvalid & w_ld;

  // Only the granted channel's data is sampled, so X elsewhere never reaches outData.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_chan[w_gidx];
      r_chan  <= w_gidx;
      if (mode) begin
        r_ptr <= w_gidx + K'(1);
      end
    end else if (outReady) begin
      r_valid <= 1'b0;
    end
  end

  assign outValid = r_valid;
  assign outData  = r_data;
  assign outChan  = r_chan;

endmodule

`default_nettype wire

// File: doc/param_arb_mux.md
PARAM_ARB_MUX -- requirements
Module: param_arb_mux

Interface
REQ-001 The module SHALL have the parameter K, default 2, meaning the select width; channel count N = 2**K.
REQ-002 The module SHALL have the parameter W, default 8, meaning the data width per channel.
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have the port mode, input, 1 bit: 0 = fixed select via sel; 1 = round-robin.
REQ-006 The module SHALL have the port sel, input, K bits: channel index, used when mode = 0.
REQ-007 The module SHALL have the port inValid, input, N bits: per-channel request.
REQ-008 The module SHALL have the port inData, input, W*N bits: channel i occupies bits [W*i+W-1 : W*i].
REQ-009 The module SHALL have the port inReady, output, N bits: per-channel accept, at most one bit high.
REQ-010 The module SHALL have the port outValid, output, 1 bit: the output register holds an item.
REQ-011 The module SHALL have the port outData, output, W bits: the registered data.
REQ-012 The module SHALL have the port outChan, output, K bits: the source channel of outData.
REQ-013 The module SHALL have the port outReady, input, 1 bit: downstream accept.

Function
REQ-014 The output stage SHALL be a single register (outValid, outData, outChan).
- load enable: ld = !outValid | outReady.
REQ-015 Grant in mode 0 SHALL be: channel sel if inValid[sel]; no grant otherwise, even if other channels are valid.
REQ-016 Grant in mode 1 SHALL be: the first i with inValid[i] set, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
REQ-017 inReady SHALL be combinational: inReady[i] = ld & grant[i]; a transfer on channel i occurs when inValid[i] & inReady[i].
REQ-018 On a transfer, the next edge SHALL perform: outData <= the channel's data, outChan <= i, outValid <= 1; latency is 1 cycle from transfer to outValid.
REQ-019 When outValid & outReady and there is no transfer, the next edge SHALL set outValid <= 0; outData and outChan hold their values.
REQ-020 When outValid & !outReady, the register SHALL hold all values and inReady SHALL be all 0 (backpressure).
REQ-021 Simultaneous output consumption and input transfer SHALL replace the register contents in the same edge, with no bubble; full throughput is one item per cycle.
REQ-022 ptr (K bits) SHALL update to (granted i + 1) mod N only on a mode-1 transfer, wrapping from N-1 to 0.
- mode-0 transfers and idle cycles leave ptr unchanged.
REQ-023 A change of mode or sel SHALL affect only arbitration in the same cycle; an item already held in the output register is unaffected.
REQ-024 An item, once presented with inValid and not yet granted, MAY be withdrawn by its source; the block SHALL make no assumption of request stability.
REQ-025 X on inData of ungranted channels SHALL NOT propagate to outputs.

Reset
REQ-026 While rst = 1, the outputs SHALL immediately be: outValid = 0, outData = 0, outChan = 0, ptr = 0, and inReady = 0.
REQ-027 Assertion of rst mid-transfer SHALL discard the held item.
- The first grant after release follows REQ-015 and REQ-016 with ptr = 0.

Verification
REQ-028 Scenario: K=2, W=8, mode=1, outReady=1, all inValid=1111 with data A0,A1,A2,A3 -> outChan SHALL be 0,1,2,3,0 on consecutive cycles; outValid SHALL be continuously 1 from cycle 1.
REQ-029 Scenario: mode=0, sel=2, inValid=1011 -> no grant and outValid stays 0; then inValid=0100 with data 5A -> inReady=0100 and next cycle outData=5A, outChan=2.
REQ-030 Scenario: outValid=1 and outReady=0 for 3 cycles with inValid=1111 -> inReady=0000 and outData is stable; on outReady=1 the next item loads in the same edge.
REQ-031 Scenario: mode=1, ptr=3, inValid=0110 -> channel 1 is granted, then ptr=2; the next grant is channel 2.
REQ-032 Scenario: rst pulsed asynchronously between edges while outValid=1 -> outValid=0 immediately; after release with inValid=1111 the first grant is channel 0.
REQ-033 Scenario: a 10k-cycle random test of mode, sel, inValid, outReady -> each transferred item appears exactly once, in order, with the correct outChan; no two inReady bits are ever high together.
